// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data memory responder for the 16-bit multi_cycle core
// Optional feature macro: MEM_BOUNDS_CHECK_EN (out-of-range detection, err flag, 16'hDEAD on loads)
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        memwrite_i,
  input  logic [15:0] dataaddr_i,
  input  logic [15:0] writedata_i,
  output logic [15:0] readdata_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] readdata_q, readdata_d;

  logic [15:0] mem_q [DEPTH];

  // Commit-side view of the transaction that is about to enter RESP
  logic          accept;
  logic          commit;
  logic          c_we;
  logic [15:0]   c_addr;
  logic [15:0]   c_wdata;
  logic [AW-1:0] c_idx;
  logic          c_oob;

  // Next-state logic: request acceptance in IDLE/RESP, wait-state countdown in WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (req_i) begin
          accept  = 1'b1;
          we_d    = memwrite_i;
          addr_d  = dataaddr_i;
          wdata_d = writedata_i;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ZERO_WAIT ? S_RESP : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the live inputs are used
  assign commit  = reset_i && (((state_q == S_WAIT) && (cnt_q == 4'd1)) || (accept && ZERO_WAIT));
  assign c_we    = (state_q == S_WAIT) ? we_q    : memwrite_i;
  assign c_addr  = (state_q == S_WAIT) ? addr_q  : dataaddr_i;
  assign c_wdata = (state_q == S_WAIT) ? wdata_q : writedata_i;
  assign c_idx   = c_addr[AW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  assign c_oob = ({1'b0, c_addr} >= DEPTH_W);
  // addr_q still holds the responding transaction during RESP
  assign err_o = (state_q == S_RESP) && ({1'b0, addr_q} >= DEPTH_W);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^c_addr;
  assign c_oob = 1'b0;
  assign err_o = 1'b0;
`endif

  // Load data register: only a load commit changes it
  always_comb begin
    readdata_d = readdata_q;
    if (commit && !c_we) begin
      readdata_d = c_oob ? 16'hDEAD : mem_q[c_idx];
    end
  end

  // RAM array: stores land on the edge entering RESP; no reset so contents survive it
  always_ff @(posedge clk_i) begin
    if (commit && c_we && !c_oob) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  // Control and request registers; reset aborts any in-flight transaction
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      readdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata_o = readdata_q;
  assign ready_o    = (state_q == S_RESP);
  assign busy_o     = (state_q == S_WAIT);

endmodule
